floating_div: RTL
=================

// Module: floating_div
// PURPOSE
//  Sequential IEEE-754 single-precision divider, o_res = i_a / i_b; companion (inverse op) of the
//  multi-cycle floating multiplier. Operands are loaded through the same i_load protocol; one
//  quotient bit is produced per cycle (restoring division); latency is fixed for all inputs.
//  Sits beside the multiplier in the FP datapath and shares its bench timing (result <= 33 cycles).
// PARAMETERS
//  WIDTH  32  operand/result width (only 32 supported)
//  EXP_W   8  exponent field width
//  MAN_W  23  stored mantissa width
// PORTS
//  i_clk     in   1      clock, rising edge
//  i_rst     in   1      reset, asynchronous, active-high
//  i_load    in   1      high: capture operands (every cycle); falling level starts the divide
//  i_a       in   WIDTH  dividend
//  i_b       in   WIDTH  divisor
//  o_res     out  WIDTH  quotient; holds last completed result
//  o_busy    out  1      high from start of UNPACK until the DONE cycle
//  o_done    out  1      one-cycle pulse when o_res is updated
// BEHAVIOUR
//  Reset: o_res=0, o_busy=0, o_done=0, state IDLE, all datapath regs 0.
//  FSM: IDLE -(i_load)-> LOAD; LOAD: regs <= i_a,i_b each edge; LOAD -(!i_load)-> UNPACK;
//   UNPACK(1) -> DIVIDE(26) -> NORM(1) -> ROUND(1): o_res written, o_done=1 -> IDLE.
//  Latency: o_done on the 29th rising edge after the edge that samples i_load=0 in LOAD.
//  i_load=1 during UNPACK..ROUND: abort, go to LOAD, o_res unchanged, no o_done.
//  Async reset mid-operation: immediate return to reset values; no partial result visible.
//  UNPACK: sign = sa^sb; subnormal inputs normalised via leading-zero count (exp 1-lzc);
//   exponent e = ea - eb + 127 held as 10-bit signed; classify zero/inf/nan.
//  DIVIDE: rem init = 24-bit mant_a; per cycle: bit = (rem >= mant_b); if set rem -= mant_b;
//   rem <<= 1; q <= {q,bit}; 26 bits, q[25] = integer bit.
//  NORM: q[25]=1: m=q[25:2], g=q[1], s=q[0]|(rem!=0); else m=q[24:1], g=q[0], s=(rem!=0), e-=1.
//   e<=0: shift m right by 1-e (saturate at 26), shifted bits fold into g/s, exp field 0.
//  ROUND: round-to-nearest-even (inc if g & (s | m[0])); mantissa carry increments exponent,
//   subnormal carry into bit 23 yields smallest normal; e >= 255 after round -> signed Inf.
//  Specials (computed in UNPACK, emitted at same fixed latency): any NaN, 0/0, Inf/Inf ->
//   0x7FC00000; x/0 (x!=0) -> signed Inf; Inf/x -> signed Inf; x/Inf, 0/x -> signed zero.
//  Signed zero results keep sign bit (e.g. -0 / 5 -> 0x80000000).
// STRUCTURE
//  fp_pkg: EXP_W, MAN_W, BIAS=127, QNAN=32'h7FC00000, POS_INF/NEG_INF, state typedef
//   {IDLE,LOAD,UNPACK,DIVIDE,NORM,ROUND}, DIV_ITERS=26.
//  Sub-module fp_lzc: combinational 24-bit leading-zero counter (reusable by multiplier path).
//  Top: FSM + iteration counter (5-bit) + remainder/quotient regs + round/pack stage.
// TESTING (bench: load high 2 cycles, then wait 35 cycles, check o_res and single o_done)
//  0x40C00000 / 0x40000000 (6/2) -> 0x40400000; 0xBF800000 / 0x40000000 -> 0xBF000000
//  0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE round-up)
//  0x3F800000 / 0x80000000 -> 0xFF800000; 0x00000000 / 0x00000000 -> 0x7FC00000
//  0x7F000000 / 0x3E800000 (overflow) -> 0x7F800000; 0x00800000 / 0x40000000 -> 0x00400000
//  abort: reassert i_load at DIVIDE cycle 10 with 6/2 -> no o_done, then 0x40400000 on rerun
//  i_rst pulse at DIVIDE cycle 5 -> o_res=0, o_busy=0 immediately; o_done latency exactly 29

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point datapath (divider and multiplier).
package fp_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int          BIAS      = 127;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF   = 32'hFF80_0000;
  localparam int unsigned DIV_ITERS = 26;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StUnpack,
    StDivide,
    StNorm,
    StRound
  } state_e;

  function automatic logic [31:0] signed_inf(input logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module fp_lzc (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd24;
    // Ascending scan so the most significant set bit wins.
    for (int i = 0; i < 24; i++) begin
      if (in_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/floating_div.sv
// Sequential single-precision divider: restoring division, one quotient bit per cycle,
// fixed latency for every operand class including specials.
module floating_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_busy,
  output logic             o_done
);
  import fp_pkg::*;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  a_q, b_q, res_q, spec_q;
  logic              sign_q, special_q, done_q, g_q, s_q;
  logic signed [9:0] e_q;
  logic [24:0]       rem_q;
  logic [23:0]       mb_q, m_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;

  // Unpack / classify
  logic [EXP_W-1:0]  expf_a, expf_b;
  logic [MAN_W-1:0]  frac_a, frac_b;
  logic [4:0]        lz_a, lz_b;
  logic [23:0]       ma, mb;
  logic signed [9:0] ea, eb, e_un;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_n, special_n;
  logic [WIDTH-1:0]  spec_n;

  assign expf_a = a_q[WIDTH-2 -: EXP_W];
  assign expf_b = b_q[WIDTH-2 -: EXP_W];
  assign frac_a = a_q[MAN_W-1:0];
  assign frac_b = b_q[MAN_W-1:0];

  fp_lzc u_lzc_a (.in_i({1'b0, frac_a}), .cnt_o(lz_a));
  fp_lzc u_lzc_b (.in_i({1'b0, frac_b}), .cnt_o(lz_b));

  always_comb begin
    zero_a = (expf_a == '0) && (frac_a == '0);
    zero_b = (expf_b == '0) && (frac_b == '0);
    inf_a  = (expf_a == '1) && (frac_a == '0);
    inf_b  = (expf_b == '1) && (frac_b == '0);
    nan_a  = (expf_a == '1) && (frac_a != '0);
    nan_b  = (expf_b == '1) && (frac_b != '0);
    sign_n = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    ma = (expf_a == '0) ? ({1'b0, frac_a} << lz_a) : {1'b1, frac_a};
    mb = (expf_b == '0) ? ({1'b0, frac_b} << lz_b) : {1'b1, frac_b};
    ea = (expf_a == '0) ? (10'sd1 - $signed({5'd0, lz_a})) : $signed({2'd0, expf_a});
    eb = (expf_b == '0) ? (10'sd1 - $signed({5'd0, lz_b})) : $signed({2'd0, expf_b});
    e_un = ea - eb + $signed(10'(BIAS));
    special_n = 1'b1;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) spec_n = QNAN;
    else if (zero_b || inf_a) spec_n = signed_inf(sign_n);
    else if (zero_a || inf_b) spec_n = {sign_n, {(WIDTH-1){1'b0}}};
    else begin
      spec_n    = '0;
      special_n = 1'b0;
    end
  end

  // Restoring divide step
  logic        q_bit;
  logic [23:0] rem_sub;
  assign q_bit   = (rem_q >= {1'b0, mb_q});
  assign rem_sub = q_bit ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];

  // Normalise, with denormalising right shift when the exponent underflows
  logic [23:0]       m_n, m_f;
  logic              g_n, s_n, g_f, s_f;
  logic signed [9:0] e_n, e_f, sh;
  logic [4:0]        sh_sat;
  logic [51:0]       wide;

  always_comb begin
    if (quo_q[25]) begin
      m_n = quo_q[25:2];
      g_n = quo_q[1];
      s_n = quo_q[0] | (rem_q != '0);
      e_n = e_q;
    end else begin
      m_n = quo_q[24:1];
      g_n = quo_q[0];
      s_n = (rem_q != '0);
      e_n = e_q - 10'sd1;
    end
    sh     = 10'sd1 - e_n;
    sh_sat = (sh > 10'sd26) ? 5'd26 : sh[4:0];
    wide   = {m_n, g_n, 27'd0} >> sh_sat;
    if (e_n <= 10'sd0) begin
      m_f = wide[51:28];
      g_f = wide[27];
      s_f = s_n | (wide[26:0] != '0);
      e_f = 10'sd0;
    end else begin
      m_f = m_n;
      g_f = g_n;
      s_f = s_n;
      e_f = e_n;
    end
  end

  // Round to nearest even and pack; a mantissa carry ripples into the exponent field
  logic             inc;
  logic [7:0]       exp_field;
  logic [30:0]      sum;
  logic [WIDTH-1:0] res_n;

  always_comb begin
    inc       = g_q & (s_q | m_q[0]);
    exp_field = (e_q > 10'sd0) ? e_q[7:0] : {7'd0, m_q[23]};
    sum       = {exp_field, m_q[22:0]} + 31'(inc);
    if (special_q)            res_n = spec_q;
    else if (e_q >= 10'sd255) res_n = signed_inf(sign_q);
    else                      res_n = {sign_q, sum};
  end

  // FSM
  logic busy;
  assign busy = (state_q == StUnpack) || (state_q == StDivide) ||
                (state_q == StNorm)   || (state_q == StRound);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_load) state_d = StLoad;
      StLoad:   if (!i_load) state_d = StUnpack;
      StUnpack: state_d = StDivide;
      StDivide: if (cnt_q == 5'(DIV_ITERS - 1)) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (busy && i_load) state_d = StLoad;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q <= '0; b_q <= '0; res_q <= '0; spec_q <= '0;
      sign_q <= 1'b0; special_q <= 1'b0; done_q <= 1'b0; g_q <= 1'b0; s_q <= 1'b0;
      e_q <= '0; rem_q <= '0; mb_q <= '0; m_q <= '0; quo_q <= '0; cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_load) begin
        a_q <= i_a;
        b_q <= i_b;
      end
      unique case (state_q)
        StUnpack: begin
          sign_q    <= sign_n;
          special_q <= special_n;
          spec_q    <= spec_n;
          e_q       <= e_un;
          rem_q     <= {1'b0, ma};
          mb_q      <= mb;
          quo_q     <= '0;
          cnt_q     <= '0;
        end
        StDivide: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[24:0], q_bit};
          cnt_q <= cnt_q + 5'd1;
        end
        StNorm: begin
          m_q <= m_f;
          g_q <= g_f;
          s_q <= s_f;
          e_q <= e_f;
        end
        StRound: begin
          if (!i_load) begin
            res_q  <= res_n;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_res  = res_q;
  assign o_busy = busy;
  assign o_done = done_q;

endmodule
